dtcm_gen: RTL and testbench
===========================

Name: dtcm_gen

Overview:
- Parametrised data tightly-coupled memory that sits between the LSU data port and the downstream data-cache/memory path.
- Requests whose address falls in a configurable window `[MEM_START, MEM_START + 4*MEM_WORDS - 1]` are served from a local word-addressed SRAM with byte-enable writes. All other requests pass through to the master side.
- Over the previous fixed-size version it adds:
  - configurable size and base;
  - configurable SRAM read latency (1 or 2 cycles);
  - an explicit single-outstanding miss state machine;
  - optional hit/miss performance counters.

Parameters:
- `MEM_START`, `32'h1ECF_1000`: byte base address of the window; must be 4-byte aligned.
- `MEM_WORDS`, `2048`: window depth in 32-bit words; power of 2, ≥ 2.
- `RD_LAT`, `1`: cycles from hit request to `slv_resp`; legal values 1 or 2.
- `CNT_W`, `32`: width of the performance counters.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset; synchronous, active-low.
- `slv_addr` input 32: request byte address.
- `slv_rmask` input 4: read byte mask; nonzero marks a read request (1-cycle pulse).
- `slv_wmask` input 4: write byte mask; nonzero marks a write request (1-cycle pulse).
- `slv_wdata` input 32: write data, byte lanes per `slv_wmask`.
- `slv_rdata` output 32: response data.
- `slv_resp` output 1: response strobe, 1 cycle per request.
- `mst_addr` output 32: forwarded address.
- `mst_rmask` output 4: forwarded read mask.
- `mst_wmask` output 4: forwarded write mask.
- `mst_wdata` output 32: forwarded write data.
- `mst_rdata` input 32: downstream response data.
- `mst_resp` input 1: downstream response strobe.
- `hit_cnt` output CNT_W: accepted in-window requests.
- `miss_cnt` output CNT_W: accepted forwarded requests.

Behaviour:
- Protocol rules:
  - Request valid = `|slv_rmask | |slv_wmask`. Address and data are valid only in that cycle.
  - At most one request is outstanding. The next request may be issued in the same cycle `slv_resp` is high, or later.
  - Simultaneous nonzero rmask and wmask is illegal.
- `hit` = `slv_addr >= MEM_START && slv_addr <= MEM_START + 4*MEM_WORDS - 1`.
  - Word index = `slv_addr[2 +: $clog2(MEM_WORDS)]`. Full index width is used; no bits are dropped.
- States: IDLE, HIT, MISS. Reset (`rst_n == 0` at a clock edge) forces IDLE, the latency counter to 0, and `hit_cnt`/`miss_cnt` to 0.
  - `slv_resp` is 0 while in reset and in the cycle after.
  - SRAM contents are not reset.
- Acceptance: a request is accepted in IDLE, or in the cycle HIT/MISS emits `slv_resp`.
  - An accepted hit moves to HIT; an accepted miss moves to MISS.
  - With no new request, the state returns to IDLE after the response.
  - Requests presented while busy with no response in the same cycle are dropped (protocol violation, assertion fires).
- Hit write:
  - Byte lanes with `slv_wmask[i]` are written at the accept edge.
  - `slv_resp` = 1 exactly `RD_LAT` cycles after the accept cycle; `slv_rdata` = 0 with it.
- Hit read:
  - The SRAM word is read at the accept edge (registered output, plus one extra pipeline register when `RD_LAT` = 2).
  - `slv_resp` = 1 exactly `RD_LAT` cycles later, with `slv_rdata` = the word.
- Read-after-write to the same word: the next accepted read returns the newly written bytes. The write completes before the read is accepted, so no bypass is needed.
- Miss:
  - `mst_rmask`/`mst_wmask` = `slv` masks for the accept cycle only.
  - On a hit they are 0; when not accepting they are 0.
  - `mst_addr` = `slv_addr` and `mst_wdata` = `slv_wdata` always (combinational).
  - The block stays in MISS until `mst_resp`. Then `slv_resp` = `mst_resp` and `slv_rdata` = `mst_rdata` in that same cycle (combinational, zero added latency).
- `mst_resp` in IDLE or HIT (for example a stale response after reset mid-miss) is ignored and never reaches `slv_resp`.
- Outside a response cycle `slv_rdata` = 0.
- Counters:
  - `hit_cnt` increments on each accepted hit; `miss_cnt` increments on each accepted miss.
  - Both saturate at all-ones.
- Boundary addresses:
  - `MEM_START` and `MEM_START + 4*MEM_WORDS - 4` are hits.
  - `MEM_START - 4` and `MEM_START + 4*MEM_WORDS` are misses.

Optional Feature:
- Macro: `DTCM_PERF_CNT_EN`.
- Defined: `hit_cnt` and `miss_cnt` are implemented as described in Behaviour.
- Undefined: no counter flops exist, and both outputs are tied to constant 0.

Test Plan:
- Reset, `RD_LAT` = 1: write `0xDEADBEEF` mask `4'hF` to `0x1ECF1000`, then read the same address in the response cycle. Required: write `slv_resp` 1 cycle after the request with `rdata` = 0, read `slv_resp` 1 cycle after its request with `rdata` `0xDEADBEEF`, `mst` masks stay 0, `hit_cnt` = 2.
- Partial write: mask `4'b0110` with data `0x11223344` to a word holding `0xDEADBEEF`, then read it. Required: `0xDE2233EF`.
- Window edges: read `0x1ECF2FFC`. Required: hit. Read `0x1ECF3000`. Required: `mst_rmask` = `4'hF` for 1 cycle; drive `mst_resp` with `0xCAFEF00D` 5 cycles later, and `slv_resp` and `rdata` `0xCAFEF00D` appear in that same cycle; `miss_cnt` = 1.
- `RD_LAT` = 2: back-to-back hit reads issued on each response cycle. Required: one response every 2 cycles, in order, with correct data.
- Assert `rst_n` = 0 mid-miss, release, then pulse `mst_resp`. Required: no `slv_resp`, state IDLE, counters 0.
- Without `DTCM_PERF_CNT_EN`: 10 mixed requests. Required: `hit_cnt` = `miss_cnt` = 0 throughout.

Source files
------------

// File: rtl/dtcm_gen.sv
// dtcm_gen: data TCM with a configurable address window and SRAM read latency; misses are forwarded to the master port.
// Define DTCM_PERF_CNT_EN to build the hit/miss counters; otherwise both count outputs are tied to 0.
module dtcm_gen #(
    parameter logic [31:0] MEM_START = 32'h1ECF_1000,
    parameter int          MEM_WORDS = 2048,
    parameter int          RD_LAT    = 1,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      slv_addr,
    input  logic [3:0]       slv_rmask,
    input  logic [3:0]       slv_wmask,
    input  logic [31:0]      slv_wdata,
    output logic [31:0]      slv_rdata,
    output logic             slv_resp,
    output logic [31:0]      mst_addr,
    output logic [3:0]       mst_rmask,
    output logic [3:0]       mst_wmask,
    output logic [31:0]      mst_wdata,
    input  logic [31:0]      mst_rdata,
    input  logic             mst_resp,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int          IW      = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_END = MEM_START + 32'(4 * MEM_WORDS) - 32'd1;

    typedef enum logic [1:0] {IDLE, HIT, MISS} state_e;

    state_e        state_q, state_d;
    logic          lat_q, lat_d;
    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   rd_q, rd2_q;
    logic          req, hit, accept, hit_resp, miss_resp, resp;
    logic [IW-1:0] idx;

    assign req       = |slv_rmask | |slv_wmask;
    assign hit       = slv_addr >= MEM_START && slv_addr <= MEM_END;
    assign idx       = slv_addr[2 +: IW];
    assign hit_resp  = state_q == HIT && lat_q == 1'(RD_LAT - 1);
    assign miss_resp = state_q == MISS && mst_resp;
    // Gating with rst_n keeps a stale downstream response from leaking out while reset is held.
    assign resp      = rst_n && (hit_resp || miss_resp);
    assign accept    = rst_n && req && (state_q == IDLE || resp);

    always_comb begin
        state_d = state_q;
        lat_d   = 1'b0;
        state_d = accept ? (hit ? HIT : MISS) : resp ? IDLE : state_q;
        lat_d   = (state_q == HIT && !accept && !resp) ? lat_q + 1'b1 : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Writes load zero into the read register so their response carries rdata = 0.
    always_ff @(posedge clk) begin
        if (accept && hit) begin
            rd_q <= |slv_rmask ? mem[idx] : '0;
            for (int i = 0; i < 4; i++)
                if (slv_wmask[i]) mem[idx][8*i +: 8] <= slv_wdata[8*i +: 8];
        end
        rd2_q <= rd_q;
    end

    assign slv_resp  = resp;
    assign slv_rdata = !resp ? '0 : hit_resp ? (RD_LAT == 2 ? rd2_q : rd_q) : mst_rdata;
    assign mst_addr  = slv_addr;
    assign mst_wdata = slv_wdata;
    assign mst_rmask = (accept && !hit) ? slv_rmask : '0;
    assign mst_wmask = (accept && !hit) ? slv_wmask : '0;

`ifdef DTCM_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (accept && hit && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (accept && !hit && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

    a_busy: assert property (@(posedge clk) disable iff (!rst_n) !(req && !accept));
    a_rw:   assert property (@(posedge clk) disable iff (!rst_n) !(|slv_rmask && |slv_wmask));
endmodule

// File: tb/tb_dtcm_gen.sv
// tb_dtcm_gen: random and directed transactions on two dtcm_gen instances (RD_LAT 1 and 2) against a word-map model.
module tb_dtcm_gen;
    localparam logic [31:0] START = 32'h1ECF_1000;
    localparam int          WORDS = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] addr[2], wdata[2], rdata[2], maddr[2], mwdata[2], mrdata[2], hc[2], mc[2];
    logic [3:0]  rmask[2], wmask[2], mrmask[2], mwmask[2];
    logic        resp[2], mresp[2];

    int          nvec = 0, nerr = 0;
    int          exp_h[2], exp_m[2];
    logic [31:0] mm[int];
    logic [31:0] last_rd;
    logic [31:0] cand[10] = '{32'h1ECF_1000, 32'h1ECF_1004, 32'h1ECF_1800, 32'h1ECF_2000,
                              32'h1ECF_2FF8, 32'h1ECF_2FFC, 32'h1ECF_0FFC, 32'h1ECF_3000,
                              32'h0000_0000, 32'hFFFF_FFFC};

    dtcm_gen #(.RD_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .slv_addr(addr[0]), .slv_rmask(rmask[0]), .slv_wmask(wmask[0]),
        .slv_wdata(wdata[0]), .slv_rdata(rdata[0]), .slv_resp(resp[0]), .mst_addr(maddr[0]),
        .mst_rmask(mrmask[0]), .mst_wmask(mwmask[0]), .mst_wdata(mwdata[0]), .mst_rdata(mrdata[0]),
        .mst_resp(mresp[0]), .hit_cnt(hc[0]), .miss_cnt(mc[0]));

    dtcm_gen #(.RD_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .slv_addr(addr[1]), .slv_rmask(rmask[1]), .slv_wmask(wmask[1]),
        .slv_wdata(wdata[1]), .slv_rdata(rdata[1]), .slv_resp(resp[1]), .mst_addr(maddr[1]),
        .mst_rmask(mrmask[1]), .mst_wmask(mwmask[1]), .mst_wdata(mwdata[1]), .mst_rdata(mrdata[1]),
        .mst_resp(mresp[1]), .hit_cnt(hc[1]), .miss_cnt(mc[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint la = longint'(a);
        return la >= longint'(START) && la < longint'(START) + 4 * WORDS;
    endfunction

    function automatic int key(input int d, input logic [31:0] a);
        return d * WORDS + int'((longint'(a) - longint'(START)) / 4);
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef DTCM_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    // Called at a negedge where the instance is idle or responding; returns at the response negedge.
    task automatic txn(input int d, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input int ml, input logic [31:0] md);
        bit          h;
        int          lat, kk;
        logic [31:0] ev, w;
        h   = in_win(a);
        lat = h ? d + 1 : ml;
        ev  = md;
        if (h) begin
            kk = key(d, a);
            w  = mm.exists(kk) ? mm[kk] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (wm[i]) w[8*i +: 8] = wd[8*i +: 8];
            mm[kk] = w;
            ev     = (rm != 0) ? w : 32'h0;
            exp_h[d]++;
        end else exp_m[d]++;
        addr[d] = a; rmask[d] = rm; wmask[d] = wm; wdata[d] = wd;
        #1;
        chk("mst_rmask", 32'(mrmask[d]), h ? 32'h0 : 32'(rm));
        chk("mst_wmask", 32'(mwmask[d]), h ? 32'h0 : 32'(wm));
        chk("mst_addr", maddr[d], a);
        chk("mst_wdata", mwdata[d], wd);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            rmask[d] = 4'h0; wmask[d] = 4'h0; addr[d] = $urandom; wdata[d] = $urandom;
            mresp[d]  = h ? 1'($urandom_range(0, 1)) : (k == lat);
            mrdata[d] = (!h && k == lat) ? md : $urandom;
            #1;
            if (k < lat) begin
                chk("busy_resp", 32'(resp[d]), 32'h0);
                chk("busy_rdata", rdata[d], 32'h0);
            end else begin
                chk("resp", 32'(resp[d]), 32'h1);
                chk("rdata", rdata[d], ev);
                last_rd = rdata[d];
                chk("hit_cnt", hc[d], cnt_exp(exp_h[d]));
                chk("miss_cnt", mc[d], cnt_exp(exp_m[d]));
            end
        end
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk);
            rmask[d] = 4'h0; wmask[d] = 4'h0; mresp[d] = 1'b0;
            #1;
            chk("idle_resp", 32'(resp[d]), 32'h0);
            chk("idle_rdata", rdata[d], 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 0; rmask[d] = 0; wmask[d] = 0; wdata[d] = 0; mrdata[d] = 0; mresp[d] = 0;
            exp_h[d] = 0; exp_m[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_resp", 32'(resp[d]), 32'h0);
            chk("rst_hit_cnt", hc[d], 32'h0);
            chk("rst_miss_cnt", mc[d], 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_resp", 32'(resp[0]), 32'h0);

        txn(0, START, 4'h0, 4'hF, 32'hDEADBEEF, 0, 32'h0);
        txn(0, START, 4'hF, 4'h0, 32'h0, 0, 32'h0);
        chk("raw_word", last_rd, 32'hDEADBEEF);
        chk("hit_cnt_two", hc[0], cnt_exp(2));
        txn(0, START, 4'h0, 4'b0110, 32'h11223344, 0, 32'h0);
        txn(0, START, 4'hF, 4'h0, 32'h0, 0, 32'h0);
        chk("partial_write", last_rd, 32'hDE2233EF);
        txn(0, 32'h1ECF_2FFC, 4'h0, 4'hF, 32'h5A5A1234, 0, 32'h0);
        txn(0, 32'h1ECF_2FFC, 4'hF, 4'h0, 32'h0, 0, 32'h0);
        chk("top_edge_hit", last_rd, 32'h5A5A1234);
        txn(0, 32'h1ECF_3000, 4'hF, 4'h0, 32'h0, 5, 32'hCAFEF00D);
        chk("miss_data", last_rd, 32'hCAFEF00D);
        chk("miss_cnt_one", mc[0], cnt_exp(1));
        idle(0, 2);

        for (int i = 0; i < 4; i++) txn(1, START + 32'(4 * i), 4'h0, 4'hF, 32'hA000_0000 + 32'(i), 0, 32'h0);
        for (int i = 0; i < 4; i++) txn(1, START + 32'(4 * i), 4'hF, 4'h0, 32'h0, 0, 32'h0);
        chk("lat2_last", last_rd, 32'hA000_0003);
        idle(1, 2);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) txn(d, cand[i], 4'h0, 4'hF, $urandom, 0, 32'h0);
            for (int n = 0; n < 120; n++) begin
                logic [31:0] a;
                bit          wr;
                a  = cand[$urandom_range(0, 9)];
                wr = 1'($urandom_range(0, 1));
                txn(d, a, wr ? 4'h0 : 4'($urandom_range(1, 15)), wr ? 4'($urandom_range(1, 15)) : 4'h0,
                    $urandom, $urandom_range(1, 4), $urandom);
                if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
            end
            idle(d, 2);
        end

        @(negedge clk);
        addr[0] = 32'h1ECF_3000; rmask[0] = 4'hF;
        #1;
        chk("rst_miss_fwd", 32'(mrmask[0]), 32'hF);
        idle(0, 2);
        @(negedge clk);
        rst_n = 1'b0; mresp[0] = 1'b1; mrdata[0] = 32'h1234_5678;
        #1;
        chk("in_rst_resp", 32'(resp[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_resp", 32'(resp[0]), 32'h0);
        @(negedge clk);
        #1;
        chk("stale_resp", 32'(resp[0]), 32'h0);
        chk("stale_rdata", rdata[0], 32'h0);
        chk("rst_hit_cnt0", hc[0], 32'h0);
        chk("rst_miss_cnt0", mc[0], 32'h0);
        idle(0, 1);
        exp_h[0] = 0; exp_m[0] = 0; exp_h[1] = 0; exp_m[1] = 0;
        txn(0, START, 4'hF, 4'h0, 32'h0, 0, 32'h0);
        txn(1, START, 4'hF, 4'h0, 32'h0, 0, 32'h0);
        idle(0, 1);
        idle(1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
